mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Single-port word memory with a latency-programmable request/response handshake.
- Sits directly downstream of the multi-cycle processor's fetch/memory states. The processor issues one request and stalls until the response arrives.
- Produces the processor's memory debug strobes: mem_read_out, mem_write_out, mem_address_out.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, byte-address width
- DEPTH_WORDS, 256, number of words stored
- LATENCY, 2, extra wait cycles before the access completes (0..15)

Ports:
- CLK  in  1  clock; all logic on rising edge
- reset  in  1  synchronous active-low reset (0 = reset)
- req_valid  in  1  request present
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_ready  out  1  unit can accept a request
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid
- rsp_err  out  1  access rejected; valid with rsp_valid
- busy  out  1  request in flight
- mem_read_out  out  1  successful read completed this cycle
- mem_write_out  out  1  successful write committed this cycle
- mem_address_out  out  ADDR_W  latched address of the current or last request

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE; req_ready=1 after the reset edge.
  - rsp_valid, rsp_err, busy, mem_read_out, mem_write_out = 0.
  - rsp_rdata=0; mem_address_out=0; wait counter=0.
  - Memory array contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On edge E0 with req_valid=1: latch write flag, addr and wdata; load counter with LATENCY; go to WAIT.
  - Inputs that change after E0 are ignored.
- WAIT:
  - req_ready=0, busy=1.
  - If counter==0, go to RESP at the next edge; otherwise decrement.
  - WAIT lasts LATENCY+1 cycles.
- RESP is entered at edge E0+LATENCY+1. The array access happens on that same edge:
  - Read: rsp_rdata = mem[addr[..:2]].
  - Write: array updated; rsp_rdata=0.
- In RESP:
  - rsp_valid=1 for exactly one cycle; busy=1.
  - mem_read_out or mem_write_out=1 for the same cycle, successful accesses only.
  - Next edge returns to IDLE. The next request can be accepted at edge E0+LATENCY+3.
- Error cases: addr[1:0]!=0 (misaligned) or word index >= DEPTH_WORDS.
  - rsp_err=1, rsp_rdata=0.
  - No array write; no mem_read_out/mem_write_out.
  - Timing is identical to a normal access.
- rsp_rdata and rsp_err hold their values until the next RESP. Only rsp_valid qualifies them.
- mem_address_out updates at acceptance (E0) and holds until the next acceptance.
- Reset mid-operation (WAIT or RESP): the access is aborted and no write is committed. A write already committed on the RESP-entry edge stays in the array.
- Read-after-write to the same address returns the new data.

Optional Feature:
- Macro MEM_BYTE_WRITE_EN.
- Defined:
  - Adds input port req_be [DATA_W/8-1:0], latched at acceptance.
  - A write updates only the enabled byte lanes.
  - req_be==0 on a write is a no-op: rsp_err=0 and mem_write_out=1.
  - Reads ignore req_be.
- Undefined: the port is absent and every write updates all lanes.

Decomposition:
- Shared package mem_access_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - DATA_W/ADDR_W defaults
  - LATENCY counter width (4)
- One sub-module is natural: mem_wait_counter (load, decrement, zero flag).
- The FSM and the array stay in mem_access_unit.

Test Plan:
- Write 0xDEADBEEF to 0x10, then read 0x10, with LATENCY=2:
  - Write: accept at E0, rsp_valid at E0+3, mem_write_out=1 in the same cycle.
  - Read: rsp_rdata=0xDEADBEEF, rsp_err=0, mem_read_out=1.
- Read addr 0x13 (misaligned) and addr 0x400 (index 256):
  - rsp_err=1, rsp_rdata=0, both strobes 0.
  - A following read of 0x10 still returns 0xDEADBEEF.
- Hold req_valid=1 continuously:
  - req_ready low from E0+1 to E0+LATENCY+2.
  - Exactly one rsp_valid per LATENCY+3 cycles.
  - Request fields changed during WAIT have no effect.
- Write 0x12345678 to 0x20 with reset=0 asserted during WAIT:
  - Outputs return to reset values after the reset edge.
  - A subsequent read of 0x20 returns the prior contents, not 0x12345678.
- LATENCY=0: accept at E0 gives rsp_valid at E0+1; back-to-back accepts every 3 cycles.
- With MEM_BYTE_WRITE_EN:
  - Write 0xAABBCCDD with req_be=4'b0101 over 0x00000000; read returns 0x00BB00DD.
  - Write with req_be=0 leaves the word unchanged.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for mem_access_unit: FSM state encoding, default bus widths
// and the wait-counter width.
package mem_access_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned CNT_W      = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Programmable wait-state counter: loads a latency value, counts down to zero
// and flags zero combinationally.
module mem_wait_counter
  import mem_access_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Single-port word memory behind a latency-programmable request/response handshake.
// Optional MEM_BYTE_WRITE_EN adds per-byte write enables (req_be).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic [ADDR_W-1:0] mem_address_out
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
`ifdef MEM_BYTE_WRITE_EN
  localparam int unsigned BE_W  = DATA_W / 8;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_enter_resp;
  logic                w_cnt_dec;
  logic                w_cnt_zero_c;

  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
`ifdef MEM_BYTE_WRITE_EN
  logic [BE_W-1:0]     r_be;
`endif

  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_busy;
  logic                r_mem_read;
  logic                r_mem_write;

  logic [DATA_W-1:0]   r_mem [DEPTH_WORDS];

  logic [ADDR_W-3:0]   w_word;
  logic [IDX_W-1:0]    w_idx;
  logic                w_err;
  logic [DATA_W-1:0]   w_wr_word;

  mem_wait_counter u_wait_counter (
    .i_clk      (CLK),
    .i_rst_n    (reset),
    .i_load     (w_accept),
    .i_load_val (CNT_W'(LATENCY)),
    .i_dec      (w_cnt_dec),
    .o_zero_c   (w_cnt_zero_c)
  );

  // Decode of the latched address; out-of-range words never touch the array.
  assign w_word = r_addr[ADDR_W-1:2];
  assign w_idx  = r_addr[IDX_W+1:2];
  assign w_err  = is_misaligned(r_addr[1:0]) || (w_word >= (ADDR_W-2)'(DEPTH_WORDS));

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    w_cnt_dec    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_cnt_zero_c) begin
          w_enter_resp = 1'b1;
          w_state_nxt  = ST_RESP;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Write word: full replace, or read-modify-merge of the enabled byte lanes.
  always_comb begin
    w_wr_word = r_wdata;
`ifdef MEM_BYTE_WRITE_EN
    w_wr_word = r_mem[w_idx];
    for (int b = 0; b < int'(BE_W); b++) begin
      if (r_be[b]) begin
        w_wr_word[8*b +: 8] = r_wdata[8*b +: 8];
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
`ifdef MEM_BYTE_WRITE_EN
      r_be        <= '0;
`endif
    end else begin
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_rsp_valid <= w_enter_resp;
      r_mem_read  <= w_enter_resp && !w_err && !r_write;
      r_mem_write <= w_enter_resp && !w_err && r_write;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
`ifdef MEM_BYTE_WRITE_EN
        r_be    <= req_be;
`endif
      end
      if (w_enter_resp) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || r_write) ? '0 : r_mem[w_idx];
      end
    end
  end

  // Array has no reset; a reset edge coinciding with RESP entry suppresses the commit.
  always_ff @(posedge CLK) begin
    if (reset && w_enter_resp && r_write && !w_err) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

  assign req_ready       = r_req_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_rdata       = r_rsp_rdata;
  assign rsp_err         = r_rsp_err;
  assign busy            = r_busy;
  assign mem_read_out    = r_mem_read;
  assign mem_write_out   = r_mem_write;
  assign mem_address_out = r_addr;

endmodule
